// File: rtl/capture_sequencer_pkg.sv
// Shared constants for the capture sequencer: command codes, state encoding, frame header.
package capture_sequencer_pkg;

  localparam logic [7:0] CMD_ARM   = 8'h41;
  localparam logic [7:0] CMD_FORCE = 8'h46;
  localparam logic [7:0] CMD_STOP  = 8'h53;
  localparam logic [7:0] CMD_DECIM = 8'h44;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/capture_sequencer_if.sv
// Command byte input and valid/ready byte output of the capture sequencer.
interface capture_sequencer_if;

  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output cmd_data, cmd_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  cmd_data, cmd_valid, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/capture_buf.sv
// Simple dual-port record buffer with registered read; no reset so it maps onto block RAM.
module capture_buf #(
  parameter int unsigned CAP_BYTES = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              wclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [CAP_BYTES];

  always_ff @(posedge wclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_sequencer.sv
// One-shot capture of the 1-bit sample stream into a byte buffer, then a framed dump
// (header + record) over a valid/ready byte stream.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int unsigned CAP_BYTES = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DECIM_W   = 8,
  parameter logic [7:0]  HDR_BYTE  = HDR_BYTE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sig,
  capture_sequencer_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                armed
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [1:0]         state_q, state_d;
  logic               sig_prev_q;
  logic [DECIM_W-1:0] decim_q, decim_d, dcnt_q, dcnt_d, dcnt_base;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic               dpend_q, dpend_d, done_q, done_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;

  logic       cmd_ok, is_arm, is_force, is_stop, is_decim;
  logic       trigger, sample, we, last_byte, fire;
  logic [7:0] wdata, rdata;

  // A pending decimation payload is consumed raw and never decoded as a command.
  assign cmd_ok   = bus.cmd_valid & ~dpend_q;
  assign is_arm   = cmd_ok && (bus.cmd_data == CMD_ARM);
  assign is_force = cmd_ok && (bus.cmd_data == CMD_FORCE);
  assign is_stop  = cmd_ok && (bus.cmd_data == CMD_STOP);
  assign is_decim = cmd_ok && (bus.cmd_data == CMD_DECIM);

  assign trigger   = (state_q == ST_ARMED) && ((sig & ~sig_prev_q) || is_force) && !is_stop;
  assign sample    = trigger || ((state_q == ST_CAPTURE) && (dcnt_q == '0));
  assign we        = sample && (bit_q == 3'd7);
  assign wdata     = {sig, shift_q[7:1]};
  assign last_byte = we && (wr_addr_q == ADDR_W'(CAP_BYTES - 1));
  assign fire      = out_valid_q && bus.out_ready;
  assign dcnt_base = trigger ? '0 : dcnt_q;

  always_comb begin
    state_d     = state_q;
    decim_d     = decim_q;
    dcnt_d      = dcnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    ld_cnt_d    = ld_cnt_q;
    dpend_d     = dpend_q;
    done_d      = done_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (bus.cmd_valid && dpend_q) begin
      decim_d = DECIM_W'(bus.cmd_data);
      dpend_d = 1'b0;
    end
    if (trigger || (state_q == ST_CAPTURE)) begin
      dcnt_d = (dcnt_base == decim_q) ? '0 : dcnt_base + DECIM_W'(1);
    end
    if (sample) begin
      shift_d = wdata;
      bit_d   = bit_q + 3'd1;
    end
    if (we) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (is_arm) begin
          state_d   = ST_ARMED;
          done_d    = 1'b0;
          bit_d     = '0;
          wr_addr_d = '0;
          rd_addr_d = '0;
        end else if (is_decim) begin
          dpend_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (is_stop) begin
          state_d = ST_IDLE;
        end else if (trigger) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (is_stop) begin
          state_d = ST_IDLE;
        end else if (last_byte) begin
          // Header goes out while the RAM fetches buffer[0].
          state_d     = ST_DRAIN;
          out_valid_d = 1'b1;
          out_data_d  = HDR_BYTE;
          rd_addr_d   = '0;
          ld_cnt_d    = '0;
        end
      end
      default: begin
        if (fire) begin
          if (ld_cnt_q != CNT_W'(CAP_BYTES)) begin
            out_data_d = rdata;
            rd_addr_d  = rd_addr_q + ADDR_W'(1);
            ld_cnt_d   = ld_cnt_q + CNT_W'(1);
          end else begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sig_prev_q  <= 1'b0;
      decim_q     <= '0;
      dcnt_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      ld_cnt_q    <= '0;
      dpend_q     <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sig_prev_q  <= sig;
      decim_q     <= decim_d;
      dcnt_q      <= dcnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      ld_cnt_q    <= ld_cnt_d;
      dpend_q     <= dpend_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Read address follows the next-state pointer so rdata always holds buffer[rd_addr_q].
  capture_buf #(
    .CAP_BYTES (CAP_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_buf (
    .wclk  (clk),
    .we    (we),
    .waddr (wr_addr_q),
    .wdata (wdata),
    .raddr (rd_addr_d),
    .rdata (rdata)
  );

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = (state_q != ST_IDLE);
  assign armed         = (state_q == ST_ARMED);
  assign done          = done_q;

endmodule
